// File: rtl/fmul_issue.sv
// Operand FIFO and issue sequencer for the multi-cycle fmul unit.
// Turns the handshake-less multiplier into a valid/ready stream stage.
module fmul_issue #(
    parameter int DEPTH = 4,
    parameter int LAT   = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_x,
    input  logic [31:0]                in_y,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [31:0]                out_data,
    output logic                       mul_req,
    output logic [31:0]                mul_x,
    output logic [31:0]                mul_y,
    input  logic [31:0]                mul_rslt,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       busy
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(LAT + 3);
    // mul_rslt lands LAT edges after the req-sampling edge, which is one edge
    // after the pop; capturing one edge later still reads a settled result.
    localparam int CAP_CNT = LAT + 1;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t        state_q, state_d;
    logic [63:0]   mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [TW-1:0] cnt_q, cnt_d;
    logic          mul_req_q, mul_req_d;
    logic          out_valid_q, out_valid_d;
    logic [31:0]   mul_x_q, mul_x_d;
    logic [31:0]   mul_y_q, mul_y_d;
    logic [31:0]   out_data_q, out_data_d;
    logic          full, push, pop;

    always_comb begin
        full        = (count_q == CW'(DEPTH));
        push        = in_valid && !full;
        pop         = 1'b0;
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        mul_req_d   = 1'b0;
        out_valid_d = out_valid_q;
        mul_x_d     = mul_x_q;
        mul_y_d     = mul_y_q;
        out_data_d  = out_data_q;

        case (state_q)
            IDLE: pop = (count_q != '0);
            WAIT: begin
                if (cnt_q == TW'(CAP_CNT)) begin
                    out_data_d  = mul_rslt;
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (count_q != '0) begin
                        pop = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop always issues immediately, so operands only change here.
        if (pop) begin
            {mul_x_d, mul_y_d} = mem_q[rd_ptr_q];
            mul_req_d          = 1'b1;
            cnt_d              = '0;
            state_d            = WAIT;
            rd_ptr_d           = rd_ptr_q + PW'(1);
        end
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_x, in_y};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            cnt_q       <= '0;
            mul_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            mul_x_q     <= '0;
            mul_y_q     <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            cnt_q       <= cnt_d;
            mul_req_q   <= mul_req_d;
            out_valid_q <= out_valid_d;
            mul_x_q     <= mul_x_d;
            mul_y_q     <= mul_y_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = !full;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign mul_req   = mul_req_q;
    assign mul_x     = mul_x_q;
    assign mul_y     = mul_y_q;
    assign count     = count_q;
    assign busy      = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_fmul_issue.sv
// Bench for fmul_issue: behavioural multiplier with fixed latency, and a
// queue of expected products in push order compared at each output handshake.
module tb_fmul_issue;
    localparam int DEPTH = 4;
    localparam int LAT   = 5;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_x = 32'h0;
    logic [31:0] in_y = 32'h0;
    logic [31:0] mul_rslt = 32'hDEADBEEF;
    logic        in_ready, out_valid, mul_req, busy;
    logic [31:0] out_data, mul_x, mul_y;
    logic [2:0]  count;

    int          n_vec = 0;
    int          n_err = 0;
    int          mdl_left = 0;
    logic [31:0] exp_q[$];
    logic        pu, po;
    logic [31:0] got, exp_v;

    fmul_issue #(.DEPTH(DEPTH), .LAT(LAT)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .mul_req(mul_req), .mul_x(mul_x), .mul_y(mul_y), .mul_rslt(mul_rslt),
        .count(count), .busy(busy)
    );

    always #5 clk = ~clk;

    // Known IEEE products for the directed pairs; any other pair gets a
    // distinctive scramble so that reordering or stale captures show up.
    function automatic logic [31:0] fmul_ref(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h3FC00000, 32'h40000000}: return 32'h40400000;
            {32'h3F800000, 32'h3F800000}: return 32'h3F800000;
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h7F7FFFFF, 32'h40000000}: return 32'h7F800000;
            {32'h00000000, 32'h3F800000}: return 32'h00000000;
            default:                      return a ^ {b[15:0], b[31:16]};
        endcase
    endfunction

    // Multiplier stand-in: reads its operand pins when the result lands.
    always @(posedge clk) begin
        if (mul_req) mdl_left <= LAT;
        else if (mdl_left > 0) mdl_left <= mdl_left - 1;
        if (mdl_left == 1) mul_rslt <= fmul_ref(mul_x, mul_y);
    end

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic drive(input logic iv, input logic [31:0] x, input logic [31:0] y,
                         input logic ordy, output logic pushed, output logic popped,
                         output logic [31:0] data);
        in_valid  = iv;
        in_x      = x;
        in_y      = y;
        out_ready = ordy;
        #1;
        pushed = iv && in_ready;
        popped = out_valid && ordy;
        data   = out_data;
        if (pushed) exp_q.push_back(fmul_ref(x, y));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        n_vec++;
        if ({in_ready, out_valid, mul_req, busy, count} !== {1'b1, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            n_err++;
            $display("[TB] FAIL reset_ctrl: got %b expected %b",
                     {in_ready, out_valid, mul_req, busy, count}, 7'b1000000);
        end
        n_vec++;
        if ({out_data, mul_x, mul_y} !== 96'd0) begin
            n_err++;
            $display("[TB] FAIL reset_data: got %h expected 0", {out_data, mul_x, mul_y});
        end
        reset = 1'b0;
    endtask

    task automatic test_single();
        drive(1'b1, 32'h3FC00000, 32'h40000000, 1'b0, pu, po, got);
        n_vec++;
        if (count !== 3'd1) begin
            n_err++; $display("[TB] FAIL single_count: got %0d expected 1", count);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        n_vec++;
        if ({mul_req, mul_x, mul_y, count} !== {1'b1, 32'h3FC00000, 32'h40000000, 3'd0}) begin
            n_err++;
            $display("[TB] FAIL single_issue: got req=%b x=%h y=%h count=%0d expected 1 3fc00000 40000000 0",
                     mul_req, mul_x, mul_y, count);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        n_vec++;
        if (mul_req !== 1'b0) begin
            n_err++; $display("[TB] FAIL single_req_pulse: got %b expected 0", mul_req);
        end
        for (int i = 3; i <= 7; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("[TB] FAIL single_early: edge k+%0d got %b expected 0", i, out_valid);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        n_vec++;
        if ({out_valid, out_data} !== {1'b1, 32'h40400000}) begin
            n_err++;
            $display("[TB] FAIL single_result: got v=%b d=%h expected 1 40400000", out_valid, out_data);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, pu, po, got);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++;
        if (!po || got !== exp_v) begin
            n_err++; $display("[TB] FAIL single_handshake: got po=%b d=%h expected 1 %h", po, got, exp_v);
        end
        n_vec++;
        if ({out_valid, busy} !== 2'b00) begin
            n_err++; $display("[TB] FAIL single_idle: got v=%b busy=%b expected 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] hold, x, y;
        logic [2:0]  c_before;
        int          npush = 0;
        drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, pu, po, got);
        for (int i = 0; i < 20 && !out_valid; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        n_vec++;
        if (out_valid !== 1'b1) begin
            n_err++; $display("[TB] FAIL bp_first: got out_valid=%b expected 1", out_valid);
        end
        hold = 32'h3F800000;
        for (int i = 0; i < 20; i++) begin
            x = (npush % 2 == 0) ? 32'h40000000 : 32'h3F800000;
            y = (npush % 2 == 0) ? 32'h40400000 : 32'h3F800000;
            drive(npush < 5, x, y, 1'b0, pu, po, got);
            if (pu) npush++;
            n_vec++;
            if ({out_valid, out_data} !== {1'b1, hold}) begin
                n_err++;
                $display("[TB] FAIL bp_hold: cycle %0d got v=%b d=%h expected 1 %h", i, out_valid, out_data, hold);
            end
        end
        n_vec++;
        if ({count, in_ready, npush[2:0]} !== {3'd4, 1'b0, 3'd4}) begin
            n_err++;
            $display("[TB] FAIL bp_full: got count=%0d in_ready=%b pushed=%0d expected 4 0 4", count, in_ready, npush);
        end
        for (int i = 0; i < 200 && (exp_q.size() != 0 || busy || npush < 5); i++) begin
            x = (npush % 2 == 0) ? 32'h40000000 : 32'h3F800000;
            y = (npush % 2 == 0) ? 32'h40400000 : 32'h3F800000;
            c_before = count;
            drive(npush < 5, x, y, 1'b1, pu, po, got);
            if (pu) npush++;
            if (po) begin
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                n_vec++;
                if (got !== exp_v) begin
                    n_err++; $display("[TB] FAIL bp_order: got %h expected %h", got, exp_v);
                end
                if (c_before != 3'd0) begin
                    n_vec++;
                    if (mul_req !== 1'b1) begin
                        n_err++; $display("[TB] FAIL bp_b2b: got mul_req=%b expected 1", mul_req);
                    end
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL bp_drain: got pending=%0d busy=%b expected 0 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_stream(input int n, input bit rnd);
        logic [31:0] xs[16], ys[16];
        int          npush = 0, nres = 0, stalls = 0;
        logic        iv;
        for (int i = 0; i < n; i++) begin
            if (rnd) begin
                xs[i] = $urandom; ys[i] = $urandom;
            end else begin
                xs[i] = (i % 2 == 0) ? 32'h3F800000 : 32'h40000000;
                ys[i] = (i % 2 == 0) ? 32'h3F800000 : 32'h40400000;
            end
        end
        for (int cyc = 0; cyc < 3000 && nres < n; cyc++) begin
            iv = (npush < n) && ($urandom_range(0, 3) != 0);
            drive(iv, xs[npush % 16], ys[npush % 16], $urandom_range(0, 2) != 0, pu, po, got);
            if (pu) npush++;
            if (iv && !pu) stalls++;
            if (po) begin
                nres++;
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                n_vec++;
                if (got !== exp_v) begin
                    n_err++; $display("[TB] FAIL stream_data: result %0d got %h expected %h", nres, got, exp_v);
                end
            end
            n_vec++;
            if (count > 3'd4 || in_ready !== (count != 3'd4)) begin
                n_err++; $display("[TB] FAIL stream_occupancy: got count=%0d in_ready=%b expected <=4 and ready=!full", count, in_ready);
            end
        end
        n_vec++;
        if (nres != n) begin
            n_err++; $display("[TB] FAIL stream_timeout: got %0d results expected %0d", nres, n);
        end
        $display("[TB] stream of %0d pairs done, %0d stalled push cycles", n, stalls);
    endtask

    task automatic test_simul();
        drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, pu, po, got);
        drive(1'b1, 32'h40000000, 32'h40400000, 1'b0, pu, po, got);
        drive(1'b1, 32'h3FC00000, 32'h40000000, 1'b0, pu, po, got);
        for (int i = 0; i < 20 && !out_valid; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        n_vec++;
        if ({out_valid, count} !== {1'b1, 3'd2}) begin
            n_err++; $display("[TB] FAIL simul_setup: got v=%b count=%0d expected 1 2", out_valid, count);
        end
        drive(1'b1, 32'h00000000, 32'h3F800000, 1'b1, pu, po, got);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++;
        if (!po || got !== exp_v) begin
            n_err++; $display("[TB] FAIL simul_pop: got po=%b d=%h expected 1 %h", po, got, exp_v);
        end
        n_vec++;
        if ({count, mul_req, mul_x, mul_y} !== {3'd2, 1'b1, 32'h40000000, 32'h40400000}) begin
            n_err++;
            $display("[TB] FAIL simul_order: got count=%0d req=%b x=%h y=%h expected 2 1 40000000 40400000",
                     count, mul_req, mul_x, mul_y);
        end
        for (int i = 0; i < 100 && (exp_q.size() != 0 || busy); i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, pu, po, got);
            if (po) begin
                exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
                n_vec++;
                if (got !== exp_v) begin
                    n_err++; $display("[TB] FAIL simul_drain: got %h expected %h", got, exp_v);
                end
            end
        end
        n_vec++;
        if (exp_q.size() != 0 || busy !== 1'b0) begin
            n_err++; $display("[TB] FAIL simul_done: got pending=%0d busy=%b expected 0 0", exp_q.size(), busy);
        end
    endtask

    task automatic test_stability();
        logic [31:0] x, y;
        for (int op = 0; op < 2; op++) begin
            x = (op == 0) ? 32'h7F7FFFFF : 32'h00000000;
            y = (op == 0) ? 32'h40000000 : 32'h3F800000;
            drive(1'b1, x, y, 1'b0, pu, po, got);
            for (int i = 0; i < 5 && !mul_req; i++) drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
            n_vec++;
            if ({mul_req, mul_x, mul_y} !== {1'b1, x, y}) begin
                n_err++; $display("[TB] FAIL stab_issue: got req=%b x=%h y=%h expected 1 %h %h", mul_req, mul_x, mul_y, x, y);
            end
            for (int i = 0; i < 20 && !out_valid; i++) begin
                drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
                n_vec++;
                if ({mul_x, mul_y} !== {x, y}) begin
                    n_err++; $display("[TB] FAIL stab_hold: got x=%h y=%h expected %h %h", mul_x, mul_y, x, y);
                end
            end
            drive(1'b0, 32'h0, 32'h0, 1'b1, pu, po, got);
            exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
            n_vec++;
            if (!po || got !== exp_v) begin
                n_err++; $display("[TB] FAIL stab_result: got po=%b d=%h expected 1 %h", po, got, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 32'h40000000, 32'h40400000, 1'b0, pu, po, got);
        drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, pu, po, got);
        repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        n_vec++;
        if ({busy, count, out_valid} !== {1'b1, 3'd1, 1'b0}) begin
            n_err++; $display("[TB] FAIL rstmid_setup: got busy=%b count=%0d v=%b expected 1 1 0", busy, count, out_valid);
        end
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        reset = 1'b0;
        n_vec++;
        if ({out_valid, count, mul_req, in_ready, busy} !== {1'b0, 3'd0, 1'b0, 1'b1, 1'b0}) begin
            n_err++;
            $display("[TB] FAIL rstmid_state: got v=%b count=%0d req=%b ready=%b busy=%b expected 0 0 0 1 0",
                     out_valid, count, mul_req, in_ready, busy);
        end
        exp_q.delete();
        drive(1'b1, 32'h3F800000, 32'h3F800000, 1'b0, pu, po, got);
        for (int i = 1; i <= 7; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
            n_vec++;
            if (out_valid !== 1'b0) begin
                n_err++; $display("[TB] FAIL rstmid_stale: edge j+%0d got v=%b d=%h expected 0", i, out_valid, out_data);
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b0, pu, po, got);
        n_vec++;
        if ({out_valid, out_data} !== {1'b1, 32'h3F800000}) begin
            n_err++; $display("[TB] FAIL rstmid_result: got v=%b d=%h expected 1 3f800000", out_valid, out_data);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, pu, po, got);
        exp_v = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
        n_vec++;
        if (!po || got !== exp_v) begin
            n_err++; $display("[TB] FAIL rstmid_handshake: got po=%b d=%h expected 1 %h", po, got, exp_v);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_single();
        test_backpressure();
        test_stream(10, 1'b0);
        test_stream(12, 1'b1);
        test_simul();
        test_stability();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
